mux_rr_arbiter: RTL

// - Round-robin arbiter sharing the 2:1 mux (inputs a/b, select sel) between two requesters.
// - Requester 0 owns mux input a (sel=0); requester 1 owns mux input b (sel=1).
// - Produces a registered one-hot grant and drives the mux sel so the owner's data reaches out.
// - Optional hold-limit counter stops one requester from starving the other.

---
 rtl/mux_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Two-requester round-robin arbiter that owns the select of a shared 2:1 mux.
//   Requester 0 owns mux input a (sel=0), requester 1 owns mux input b (sel=1).
//   All outputs are registered and decoded from the next state, so a grant
//   shows up one clock after the request is first sampled high.
//
//   Optional feature: define ARB_TIMEOUT_EN to enable the hold-limit counter
//   that forces rotation after MAX_HOLD consecutive grant cycles when the
//   other requester is waiting.
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous, active-high reset
//   req    in   2  level requests; req[0] -> mux a, req[1] -> mux b
//   gnt    out  2  registered one-hot grant, 2'b00 when idle
//   sel    out  1  registered mux select; holds its value while idle
//   busy   out  1  registered, high while a grant is active
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy
);

  if (MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
    $error("mux_rr_arbiter: need MAX_HOLD >= 1 and 2**CNT_W > MAX_HOLD");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q,  last_d;
  logic [1:0] gnt_q,   gnt_d;
  logic       sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic       entry;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             at_limit;
  assign at_limit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case (req)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          // Tie goes to whoever was not granted last.
          2'b11:   state_d = last_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end
      GNT0: begin
        if (req[0]) begin
`ifdef ARB_TIMEOUT_EN
          if (at_limit && req[1]) state_d = GNT1;
`endif
        end else if (req[1]) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (req[1]) begin
`ifdef ARB_TIMEOUT_EN
          if (at_limit && req[0]) state_d = GNT0;
`endif
        end else if (req[0]) begin
          state_d = GNT0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry into a grant state, including direct GNT0<->GNT1 hand-over.
    entry  = (state_d != state_q) && (state_d != IDLE);
    last_d = entry ? (state_d == GNT1) : last_q;

    gnt_d  = {state_d == GNT1, state_d == GNT0};
    busy_d = (state_d != IDLE);
    // Keep the mux pointed at the last owner while idle so out stays stable.
    sel_d  = (state_d == IDLE) ? sel_q : (state_d == GNT1);

`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    if (entry) begin
      hold_cnt_d = '0;
    end else if (((state_d == GNT0) && req[0]) || ((state_d == GNT1) && req[1])) begin
      if (!at_limit) hold_cnt_d = hold_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
